param_updown_counter: RTL and testbench

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

---
 rtl/param_updown_counter.sv | 149 ++++++++++++++
 tb/tb_param_updown_counter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/param_updown_counter.sv
// Up/down counter with a VERIFY/INC/DEC/LOAD/INIT control FSM.
// Supports saturating or modulo limits, an optional edge-detected request mode and clamped loads.
module param_updown_counter #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH - 1,
  parameter int STEP    = 1,
  parameter int WRAP    = 0,
  parameter int EDGE    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             u,
  input  logic             d,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] count,
  output logic             z,
  output logic             m,
  output logic             op,
  output logic             busy,
  output logic             ovf,
  output logic             unf
);

  // One extra bit keeps count+STEP and count+MAX_VAL+1 exact before any compare.
  localparam logic [WIDTH:0] MAX_X  = MAX_VAL[WIDTH:0];
  localparam logic [WIDTH:0] STEP_X = STEP[WIDTH:0];
  localparam logic [WIDTH:0] MOD_X  = MAX_X + 1'b1;

  typedef enum logic [2:0] {
    S_INIT,
    S_VERIFY,
    S_INC,
    S_DEC,
    S_LOAD
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] ld_val_q, ld_val_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             u_prev_q, d_prev_q;
  logic             u_req, d_req;
  logic [WIDTH:0]   res;

  // Result packing for all three helpers: {limit_hit, new_count}.
  function automatic logic [WIDTH:0] step_up(input logic [WIDTH-1:0] c);
    logic [WIDTH:0] sum;
    sum = {1'b0, c} + STEP_X;
    if (sum > MAX_X)
      step_up = {1'b1, (WRAP != 0) ? WIDTH'(sum - MOD_X) : MAX_X[WIDTH-1:0]};
    else
      step_up = {1'b0, sum[WIDTH-1:0]};
  endfunction

  function automatic logic [WIDTH:0] step_down(input logic [WIDTH-1:0] c);
    if ({1'b0, c} < STEP_X)
      step_down = {1'b1, (WRAP != 0) ? WIDTH'({1'b0, c} + MOD_X - STEP_X) : {WIDTH{1'b0}}};
    else
      step_down = {1'b0, WIDTH'({1'b0, c} - STEP_X)};
  endfunction

  function automatic logic [WIDTH:0] clamp_load(input logic [WIDTH-1:0] v);
    if ({1'b0, v} > MAX_X)
      clamp_load = {1'b1, MAX_X[WIDTH-1:0]};
    else
      clamp_load = {1'b0, v};
  endfunction

  assign u_req = (EDGE != 0) ? (u & ~u_prev_q) : u;
  assign d_req = (EDGE != 0) ? (d & ~d_prev_q) : d;

  assign count = count_q;
  assign z     = (count_q != '0);
  assign m     = ({1'b0, count_q} < MAX_X);
  assign op    = (state_q == S_DEC);
  assign busy  = (state_q != S_VERIFY);
  assign ovf   = ovf_q;
  assign unf   = unf_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    ld_val_d = ld_val_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    res      = '0;
    case (state_q)
      S_INIT: begin
        count_d = '0;
        state_d = S_VERIFY;
      end
      S_VERIFY: begin
        if (ld) begin
          ld_val_d = ld_val;
          state_d  = S_LOAD;
        end else if (u_req && !d_req) begin
          if ((WRAP != 0) || m) state_d = S_INC;
        end else if (d_req && !u_req) begin
          if ((WRAP != 0) || z) state_d = S_DEC;
        end
      end
      S_INC: begin
        res     = step_up(count_q);
        count_d = res[WIDTH-1:0];
        ovf_d   = res[WIDTH];
        state_d = S_VERIFY;
      end
      S_DEC: begin
        res     = step_down(count_q);
        count_d = res[WIDTH-1:0];
        unf_d   = res[WIDTH];
        state_d = S_VERIFY;
      end
      S_LOAD: begin
        res     = clamp_load(ld_val_q);
        count_d = res[WIDTH-1:0];
        ovf_d   = res[WIDTH];
        state_d = S_VERIFY;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_INIT;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      u_prev_q <= 1'b0;
      d_prev_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      u_prev_q <= u;
      d_prev_q <= d;
    end
  end

  // Load operand is pure data; it is only consumed in LOAD after being captured in VERIFY.
  always_ff @(posedge clk) begin
    ld_val_q <= ld_val_d;
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: three configurations share one stimulus stream,
// each check targets the instance whose configuration the scenario exercises.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       reset, u, d, ld;
  logic [3:0] ld_val;
  logic [3:0] cnt [3];
  logic [2:0] z_w, m_w, op_w, busy_w, ovf_w, unf_w;

  always #5 clk = ~clk;

  // 0: saturating STEP=1, 1: wrapping STEP=3, 2: saturating edge-triggered
  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .STEP(1), .WRAP(0), .EDGE(0)) dut_a (
    .clk(clk), .reset(reset), .u(u), .d(d), .ld(ld), .ld_val(ld_val),
    .count(cnt[0]), .z(z_w[0]), .m(m_w[0]), .op(op_w[0]), .busy(busy_w[0]),
    .ovf(ovf_w[0]), .unf(unf_w[0]));

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .STEP(3), .WRAP(1), .EDGE(0)) dut_b (
    .clk(clk), .reset(reset), .u(u), .d(d), .ld(ld), .ld_val(ld_val),
    .count(cnt[1]), .z(z_w[1]), .m(m_w[1]), .op(op_w[1]), .busy(busy_w[1]),
    .ovf(ovf_w[1]), .unf(unf_w[1]));

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .STEP(1), .WRAP(0), .EDGE(1)) dut_c (
    .clk(clk), .reset(reset), .u(u), .d(d), .ld(ld), .ld_val(ld_val),
    .count(cnt[2]), .z(z_w[2]), .m(m_w[2]), .op(op_w[2]), .busy(busy_w[2]),
    .ovf(ovf_w[2]), .unf(unf_w[2]));

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int sel;
    int ec;
    int eo;
    int eu;
    int due;
  } exp_t;

  typedef struct {
    int sel;
    int kind;   // 0 load, 1 up, 2 down, 3 reset
    int val;
    int ec;
    int eo;
    int eu;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[19];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and retire any scoreboard entries that are due.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    cyc++;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk("sb_count", int'(cnt[e.sel]), e.ec);
      chk("sb_ovf", int'(ovf_w[e.sel]), e.eo);
      chk("sb_unf", int'(unf_w[e.sel]), e.eu);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    u = 1'b0; d = 1'b0; ld = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  // One-cycle request from VERIFY; result is due two falling edges later.
  task automatic apply(input vec_t v);
    exp_t e;
    case (v.kind)
      0: begin ld = 1'b1; ld_val = 4'(v.val); end
      1: u = 1'b1;
      default: d = 1'b1;
    endcase
    e.sel = v.sel; e.ec = v.ec; e.eo = v.eo; e.eu = v.eu; e.due = cyc + 2;
    sbq.push_back(e);
    cycle();
    u = 1'b0; d = 1'b0; ld = 1'b0;
    cycle();
  endtask

  initial begin
    int ovf_seen;
    int expc;
    vec_t v;

    tbl[0]  = '{0, 3, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 8, 8, 0, 0};
    tbl[2]  = '{1, 1, 0, 1, 1, 0};
    tbl[3]  = '{1, 2, 0, 8, 0, 1};
    tbl[4]  = '{1, 2, 0, 5, 0, 0};
    tbl[5]  = '{1, 2, 0, 2, 0, 0};
    tbl[6]  = '{1, 2, 0, 9, 0, 1};
    tbl[7]  = '{1, 1, 0, 2, 1, 0};
    tbl[8]  = '{1, 0, 15, 9, 1, 0};
    tbl[9]  = '{1, 1, 0, 2, 1, 0};
    tbl[10] = '{0, 3, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 12, 9, 1, 0};
    tbl[12] = '{0, 1, 0, 9, 0, 0};
    tbl[13] = '{0, 2, 0, 8, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 0};
    tbl[15] = '{0, 2, 0, 0, 0, 0};
    tbl[16] = '{0, 0, 9, 9, 0, 0};
    tbl[17] = '{0, 1, 0, 9, 0, 0};
    tbl[18] = '{2, 2, 0, 8, 0, 0};

    reset = 1'b1; u = 1'b0; d = 1'b0; ld = 1'b0; ld_val = 4'd0;
    cycle();
    cycle();
    chk("rst_count", int'(cnt[0]), 0);
    chk("rst_busy", int'(busy_w[0]), 1);
    chk("rst_op", int'(op_w[0]), 0);
    chk("rst_z", int'(z_w[0]), 0);
    chk("rst_m", int'(m_w[0]), 1);
    chk("rst_ovf", int'(ovf_w[0]), 0);
    chk("rst_unf", int'(unf_w[0]), 0);
    reset = 1'b0;
    cycle();
    chk("post_rst_busy", int'(busy_w[0]), 0);

    for (int i = 0; i < 19; i++) begin
      v = tbl[i];
      if (v.kind == 3) do_reset();
      else apply(v);
    end

    // Level u held from reset release: one step every two cycles, then hold at the limit.
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    u = 1'b1;
    ovf_seen = 0;
    for (int k = 1; k <= 30; k++) begin
      cycle();
      expc = ((k - 1) / 2 > 9) ? 9 : (k - 1) / 2;
      chk("hold_u_count", int'(cnt[0]), expc);
      if (ovf_w[0]) ovf_seen++;
    end
    u = 1'b0;
    chk("hold_u_m", int'(m_w[0]), 0);
    chk("hold_u_busy", int'(busy_w[0]), 0);
    chk("hold_u_ovf_pulses", ovf_seen, 0);

    // Conflicting u and d are ignored; then a clamped load.
    do_reset();
    apply('{0, 0, 4, 4, 0, 0});
    u = 1'b1; d = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("ud_busy", int'(busy_w[0]), 0);
      chk("ud_count", int'(cnt[0]), 4);
    end
    u = 1'b0; d = 1'b0;
    apply('{0, 0, 12, 9, 1, 0});
    cycle();
    chk("ld_ovf_pulse_end", int'(ovf_w[0]), 0);

    // Edge mode: a long u high counts once.
    do_reset();
    u = 1'b1;
    for (int k = 0; k < 10; k++) cycle();
    u = 1'b0;
    cycle();
    cycle();
    chk("edge_count", int'(cnt[2]), 1);

    // Reset landing on the DEC cycle discards the decrement.
    do_reset();
    apply('{0, 0, 5, 5, 0, 0});
    d = 1'b1;
    cycle();
    chk("dec_op", int'(op_w[0]), 1);
    d = 1'b0;
    reset = 1'b1;
    cycle();
    chk("dec_rst_count", int'(cnt[0]), 0);
    chk("dec_rst_unf", int'(unf_w[0]), 0);
    chk("dec_rst_busy", int'(busy_w[0]), 1);
    reset = 1'b0;
    cycle();
    chk("dec_rst_verify", int'(busy_w[0]), 0);
    chk("dec_rst_unf2", int'(unf_w[0]), 0);
    chk("dec_rst_count2", int'(cnt[0]), 0);

    // Down request at zero with saturation is blocked.
    do_reset();
    d = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      d = 1'b0;
      chk("zero_d_op", int'(op_w[0]), 0);
      chk("zero_d_busy", int'(busy_w[0]), 0);
      chk("zero_d_count", int'(cnt[0]), 0);
    end

    chk("sb_drain", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
